// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte push handshake between the register block and the UART TX PHY
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_phy.sv
// rtl/uart_tx_phy.sv - byte FIFO plus 8N1 serialiser driving txd
module uart_tx_phy #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   tx_if,
  output logic       txd_o,
  output logic       tx_busy_o,
  output logic       overflow_o,
  input  logic       ovf_clear_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
  localparam logic [AW:0]   PTR_ONE      = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      shift_q, shift_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            txd_q, txd_d;
  logic            tx_ready_q;
  logic            overflow_q, overflow_d;
  logic            empty, full, full_next;
  logic            push, pop;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign full_next = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);

  // A push arriving while full is dropped even if a pop frees an entry on the same edge.
  assign push = tx_if.tx_valid && !full;

  assign tx_if.tx_ready = tx_ready_q;
  assign txd_o          = txd_q;
  assign overflow_o     = overflow_q;
  assign tx_busy_o      = (state_q != IDLE) || !empty;

  // Next-state logic for the frame FSM, bit timer, shifter and FIFO pop.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q[AW-1:0]];
          timer_d = TIMER_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (timer_q == '0) begin
          timer_d   = TIMER_RELOAD;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          shift_d   = {1'b0, shift_q[7:1]};
          timer_d   = TIMER_RELOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      STOP: begin
        if (timer_q == '0) begin
          // Pop straight into the next start bit so consecutive frames have no gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q[AW-1:0]];
            timer_d = TIMER_RELOAD;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer, line level and sticky overflow next-state.
  always_comb begin
    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    overflow_d = overflow_q;
    if (ovf_clear_i) begin
      overflow_d = 1'b0;
    end
    if (tx_if.tx_valid && full) begin
      overflow_d = 1'b1;
    end
    txd_d = 1'b1;
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  // Control and status registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shift_q    <= '0;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      txd_q      <= 1'b1;
      tx_ready_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shift_q    <= shift_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      txd_q      <= txd_d;
      tx_ready_q <= !full_next;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= tx_if.tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_phy.sv
// tb/tb_uart_tx_phy.sv - self-checking bench for uart_tx_phy
module tb_uart_tx_phy;
  localparam int C  = 4;
  localparam int C2 = 434;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd1, busy1, ovf1, clr1;
  logic txd2, busy2, ovf2, clr2;

  uart_tx_if bus1 ();
  uart_tx_if bus2 ();

  uart_tx_phy #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_if(bus1), .txd_o(txd1), .tx_busy_o(busy1),
    .overflow_o(ovf1), .ovf_clear_i(clr1)
  );

  uart_tx_phy #(.CLKS_PER_BIT(C2), .FIFO_DEPTH(4)) dut_slow (
    .clk(clk), .rst(rst), .tx_if(bus2), .txd_o(txd2), .tx_busy_o(busy2),
    .overflow_o(ovf2), .ovf_clear_i(clr2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         rec_txd[$];
  logic         rec_busy[$];
  logic         rec_rdy[$];
  logic         rec_ovf[$];
  logic [7:0]   dec_byte[$];
  int           dec_start[$];
  int           dec_bad;

  task automatic rec_clear();
    rec_txd.delete(); rec_busy.delete(); rec_rdy.delete(); rec_ovf.delete();
  endtask

  // One clock of stimulus on the fast instance; record index i = state after edge i.
  task automatic cycle(input logic v, input logic [7:0] d, input logic clr);
    bus1.tx_valid = v;
    bus1.tx_data  = d;
    clr1          = clr;
    @(negedge clk);
    rec_txd.push_back(txd1);
    rec_busy.push_back(busy1);
    rec_rdy.push_back(bus1.tx_ready);
    rec_ovf.push_back(ovf1);
    bus1.tx_valid = 1'b0;
    clr1          = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  // Reference 8N1 receiver: every cell of each bit must hold one level for c cycles.
  task automatic decode(input int c);
    int i;
    int n;
    logic lvl;
    logic [7:0] b;
    i = 0;
    n = rec_txd.size();
    dec_byte.delete(); dec_start.delete(); dec_bad = 0;
    while (i < n) begin
      if (rec_txd[i] !== 1'b0 && rec_txd[i] !== 1'b1) begin
        dec_bad++;
        i++;
      end else if (rec_txd[i] === 1'b0) begin
        if (i + 10 * c > n) begin
          dec_bad++;
          i = n;
        end else begin
          b = 8'h00;
          for (int k = 0; k < 10; k++) begin
            lvl = rec_txd[i + k * c + c / 2];
            if (k >= 1 && k <= 8) b[k-1] = lvl;
            if ((k == 0 && lvl !== 1'b0) || (k == 9 && lvl !== 1'b1)) dec_bad++;
            for (int j = 0; j < c; j++) begin
              if (rec_txd[i + k * c + j] !== lvl) dec_bad++;
            end
          end
          dec_byte.push_back(b);
          dec_start.push_back(i);
          i += 10 * c;
        end
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (txd1 !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd1); end
    checks++; if (bus1.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus1.tx_ready); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf1); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    rec_clear();
    cycle(1'b1, 8'hA5, 1'b0);
    idle(59);
    decode(C);
    checks++; if (dec_byte.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", dec_byte.size()); end
    checks++; if (dec_byte.size() < 1 || dec_byte[0] !== 8'hA5) begin errors++; $display("FAIL single_byte: got %h want a5", (dec_byte.size() > 0) ? dec_byte[0] : 8'hxx); end
    checks++; if (dec_start.size() < 1 || dec_start[0] != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", (dec_start.size() > 0) ? dec_start[0] : -1); end
    checks++; if (dec_bad != 0) begin errors++; $display("FAIL single_shape: got %0d bad cells want 0", dec_bad); end
    checks++; if (rec_busy[0] !== 1'b1 || rec_busy[39] !== 1'b1) begin errors++; $display("FAIL single_busy_on: got %b%b want 11", rec_busy[0], rec_busy[39]); end
    checks++; if (rec_busy[43] !== 1'b0 || rec_txd[43] !== 1'b1) begin errors++; $display("FAIL single_busy_off: got busy %b txd %b want 0 1", rec_busy[43], rec_txd[43]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[3];
    int rdy_low;
    exp_b[0] = 8'h55; exp_b[1] = 8'h0F; exp_b[2] = 8'hFF;
    rec_clear();
    for (int k = 0; k < 3; k++) cycle(1'b1, exp_b[k], 1'b0);
    idle(130);
    decode(C);
    rdy_low = 0;
    foreach (rec_rdy[k]) if (rec_rdy[k] !== 1'b1) rdy_low++;
    checks++; if (dec_byte.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", dec_byte.size()); end
    for (int k = 0; k < 3 && k < dec_byte.size(); k++) begin
      checks++; if (dec_byte[k] !== exp_b[k] || dec_start[k] != 2 + 40 * k) begin
        errors++; $display("FAIL b2b_frame%0d: got %h@%0d want %h@%0d", k, dec_byte[k], dec_start[k], exp_b[k], 2 + 40 * k);
      end
    end
    checks++; if (dec_bad != 0) begin errors++; $display("FAIL b2b_shape: got %0d bad cells want 0", dec_bad); end
    checks++; if (rdy_low != 0) begin errors++; $display("FAIL b2b_ready: got %0d low cycles want 0", rdy_low); end
  endtask

  task automatic test_overflow();
    logic [7:0] b[6];
    rec_clear();
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    for (int k = 0; k < 6; k++) cycle(1'b1, b[k], 1'b0);
    idle(210);
    decode(C);
    checks++; if (rec_rdy[3] !== 1'b1 || rec_rdy[4] !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b%b want 10", rec_rdy[3], rec_rdy[4]); end
    checks++; if (rec_ovf[4] !== 1'b0 || rec_ovf[5] !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b%b want 01", rec_ovf[4], rec_ovf[5]); end
    checks++; if (rec_ovf[rec_ovf.size()-1] !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", rec_ovf[rec_ovf.size()-1]); end
    checks++; if (dec_byte.size() != 5) begin errors++; $display("FAIL ovf_count: got %0d want 5", dec_byte.size()); end
    for (int k = 0; k < 5 && k < dec_byte.size(); k++) begin
      checks++; if (dec_byte[k] !== b[k] || dec_start[k] != 2 + 40 * k) begin
        errors++; $display("FAIL ovf_frame%0d: got %h@%0d want %h@%0d", k, dec_byte[k], dec_start[k], b[k], 2 + 40 * k);
      end
    end
    checks++; if (dec_bad != 0) begin errors++; $display("FAIL ovf_shape: got %0d bad cells want 0", dec_bad); end
  endtask

  task automatic test_pop_race();
    logic [7:0] b[8];
    logic [7:0] exp_b[6];
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (rec_ovf[rec_ovf.size()-1] !== 1'b0) begin errors++; $display("FAIL race_preclear: got %b want 0", rec_ovf[rec_ovf.size()-1]); end
    for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
    rec_clear();
    for (int k = 0; k < 5; k++) cycle(1'b1, b[k], 1'b0);
    idle(36);
    cycle(1'b1, b[5], 1'b0);
    idle(3);
    cycle(1'b0, 8'h00, 1'b1);
    idle(4);
    cycle(1'b1, b[6], 1'b0);
    cycle(1'b1, b[7], 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    idle(210);
    decode(C);
    checks++; if (rec_ovf[40] !== 1'b0 || rec_ovf[41] !== 1'b1) begin errors++; $display("FAIL race_drop: got %b%b want 01", rec_ovf[40], rec_ovf[41]); end
    checks++; if (rec_rdy[40] !== 1'b0 || rec_rdy[41] !== 1'b1) begin errors++; $display("FAIL race_ready: got %b%b want 01", rec_rdy[40], rec_rdy[41]); end
    checks++; if (rec_ovf[44] !== 1'b1 || rec_ovf[45] !== 1'b0) begin errors++; $display("FAIL race_clear: got %b%b want 10", rec_ovf[44], rec_ovf[45]); end
    checks++; if (rec_rdy[50] !== 1'b0 || rec_ovf[51] !== 1'b1 || rec_ovf[52] !== 1'b0) begin
      errors++; $display("FAIL race_clear_vs_drop: got rdy %b ovf %b%b want 0 10", rec_rdy[50], rec_ovf[51], rec_ovf[52]);
    end
    exp_b[0] = b[0]; exp_b[1] = b[1]; exp_b[2] = b[2]; exp_b[3] = b[3]; exp_b[4] = b[4]; exp_b[5] = b[6];
    checks++; if (dec_byte.size() != 6) begin errors++; $display("FAIL race_count: got %0d want 6", dec_byte.size()); end
    for (int k = 0; k < 6 && k < dec_byte.size(); k++) begin
      checks++; if (dec_byte[k] !== exp_b[k] || dec_start[k] != 2 + 40 * k) begin
        errors++; $display("FAIL race_frame%0d: got %h@%0d want %h@%0d", k, dec_byte[k], dec_start[k], exp_b[k], 2 + 40 * k);
      end
    end
    checks++; if (dec_bad != 0) begin errors++; $display("FAIL race_shape: got %0d bad cells want 0", dec_bad); end
  endtask

  task automatic test_reset_mid_frame();
    int bad_txd;
    int bad_busy;
    rec_clear();
    cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 8'($urandom), 1'b0);
    idle(57);
    checks++; if (rec_txd[60] !== 1'b0 || rec_busy[60] !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got txd %b busy %b want 0 1", rec_txd[60], rec_busy[60]); end
    rst = 1'b1;
    #1;
    checks++; if (txd1 !== 1'b1) begin errors++; $display("FAIL rstmid_txd: got %b want 1", txd1); end
    checks++; if (bus1.tx_ready !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL rstmid_status: got rdy %b busy %b want 1 0", bus1.tx_ready, busy1); end
    @(negedge clk);
    rst = 1'b0;
    rec_clear();
    idle(120);
    bad_txd = 0;
    bad_busy = 0;
    foreach (rec_txd[k]) begin
      if (rec_txd[k] !== 1'b1) bad_txd++;
      if (rec_busy[k] !== 1'b0 || rec_rdy[k] !== 1'b1) bad_busy++;
    end
    checks++; if (bad_txd != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d non-idle cycles want 0", bad_txd); end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL rstmid_empty: got %0d busy cycles want 0", bad_busy); end
  endtask

  task automatic test_random();
    logic [7:0] exp_b[$];
    int exp_s[$];
    int first;
    int len;
    int guard;
    int rdy_low;
    logic [7:0] v;
    rec_clear();
    for (int bi = 0; bi < 10; bi++) begin
      len = $urandom_range(1, 4);
      first = rec_txd.size();
      for (int j = 0; j < len; j++) begin
        v = 8'($urandom);
        cycle(1'b1, v, 1'b0);
        exp_b.push_back(v);
        exp_s.push_back(first + 2 + 40 * j);
        if (j < len - 1) idle($urandom_range(0, 2));
      end
      guard = 0;
      while (guard < 400) begin
        cycle(1'b0, 8'h00, 1'b0);
        if (rec_busy[rec_busy.size()-1] === 1'b0) break;
        guard++;
      end
      if (guard >= 400) begin
        checks++; errors++; $display("FAIL rand_timeout: busy still %b after %0d cycles want 0", busy1, guard);
      end
      idle($urandom_range(0, 15));
    end
    decode(C);
    rdy_low = 0;
    foreach (rec_rdy[k]) if (rec_rdy[k] !== 1'b1) rdy_low++;
    checks++; if (dec_byte.size() != exp_b.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", dec_byte.size(), exp_b.size()); end
    for (int k = 0; k < exp_b.size() && k < dec_byte.size(); k++) begin
      checks++; if (dec_byte[k] !== exp_b[k] || dec_start[k] != exp_s[k]) begin
        errors++; $display("FAIL rand_frame%0d: got %h@%0d want %h@%0d", k, dec_byte[k], dec_start[k], exp_b[k], exp_s[k]);
      end
    end
    checks++; if (dec_bad != 0) begin errors++; $display("FAIL rand_shape: got %0d bad cells want 0", dec_bad); end
    checks++; if (rdy_low != 0) begin errors++; $display("FAIL rand_ready: got %0d low cycles want 0", rdy_low); end
  endtask

  task automatic test_slow_baud();
    int zeros;
    rec_clear();
    @(negedge clk);
    bus2.tx_valid = 1'b1;
    bus2.tx_data  = 8'h41;
    @(negedge clk);
    bus2.tx_valid = 1'b0;
    rec_txd.push_back(txd2);
    rec_busy.push_back(busy2);
    for (int k = 1; k < 4400; k++) begin
      @(negedge clk);
      rec_txd.push_back(txd2);
      rec_busy.push_back(busy2);
    end
    decode(C2);
    zeros = 0;
    for (int k = 2; k < 4400 && rec_txd[k] === 1'b0; k++) zeros++;
    checks++; if (zeros != C2) begin errors++; $display("FAIL slow_start_width: got %0d want %0d", zeros, C2); end
    checks++; if (dec_byte.size() != 1 || dec_byte[0] !== 8'h41) begin errors++; $display("FAIL slow_byte: got %0d frames first %h want 1 41", dec_byte.size(), (dec_byte.size() > 0) ? dec_byte[0] : 8'hxx); end
    checks++; if (dec_start.size() < 1 || dec_start[0] != 2) begin errors++; $display("FAIL slow_latency: got %0d want 2", (dec_start.size() > 0) ? dec_start[0] : -1); end
    checks++; if (dec_bad != 0) begin errors++; $display("FAIL slow_shape: got %0d bad cells want 0", dec_bad); end
    checks++; if (rec_txd[2 + 9 * C2 - 1] !== 1'b0 || rec_txd[2 + 9 * C2] !== 1'b1) begin
      errors++; $display("FAIL slow_bit7_end: got %b%b want 01", rec_txd[2 + 9 * C2 - 1], rec_txd[2 + 9 * C2]);
    end
    checks++; if (rec_busy[4339] !== 1'b1 || rec_busy[4343] !== 1'b0) begin errors++; $display("FAIL slow_busy: got %b%b want 10", rec_busy[4339], rec_busy[4343]); end
  endtask

  initial begin
    bus1.tx_valid = 1'b0; bus1.tx_data = 8'h00; clr1 = 1'b0;
    bus2.tx_valid = 1'b0; bus2.tx_data = 8'h00; clr2 = 1'b0;
    @(negedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_pop_race();
    test_reset_mid_frame();
    test_random();
    test_slow_baud();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
